// File: rtl/btn_debounce_fsm.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, press/release
// strobes, one-shot long-press strobe and a wrapping 8-bit press counter.
// All outputs are registered and change on the same edge as the state move
// that causes them.
module btn_debounce_fsm #(
  parameter int DEBOUNCE_CYCLES   = 540000,
  parameter int LONG_PRESS_CYCLES = 27000000,
  parameter bit ACTIVE_LOW        = 1'b0,
  parameter int CNT_W             = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  // Hold time stops counting once the long-press threshold is reached.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v < LP_LAST) ? v + CNT_W'(1) : v;
  endfunction

  logic             sync1_q, sync2_q;
  logic             b;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_fired_q, long_fired_d;
  logic             btn_level_q, btn_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             long_press_q, long_press_d;
  logic [7:0]       press_count_q, press_count_d;

  // Two-flop synchroniser; resets to the idle pad level so no false press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Normalised button: 1 means pressed regardless of board wiring.
  assign b = sync2_q ^ ACTIVE_LOW;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      long_fired_q    <= 1'b0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_press_q    <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      long_fired_q    <= long_fired_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_press_q    <= long_press_d;
      press_count_q   <= press_count_d;
    end
  end

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    long_fired_d    = long_fired_q;
    btn_level_d     = btn_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_press_d    = 1'b0;
    press_count_d   = press_count_q;
    case (state_q)
      IDLE: begin
        if (b) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!b) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d       = PRESSED;
          btn_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
          hold_cnt_d    = '0;
          long_fired_d  = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if ((hold_cnt_q == LP_LAST) && !long_fired_q) begin
          long_press_d = 1'b1;
          long_fired_d = 1'b1;
        end
        if (!b) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end else begin
          hold_cnt_d = sat_inc(hold_cnt_q);
        end
      end
      RELEASE_WAIT: begin
        if (b) begin
          // A release bounce: resume the press with hold time intact.
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d         = IDLE;
          btn_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        db_cnt_d      = '0;
        hold_cnt_d    = '0;
        long_fired_d  = 1'b0;
        btn_level_d   = 1'b0;
        press_count_d = 8'd0;
      end
    endcase
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_press    = long_press_q;
  assign press_count   = press_count_q;

endmodule

// File: doc/btn_debounce_fsm.md
Name: btn_debounce_fsm

Overview:
Conditions a raw mechanical push-button into clean, clock-synchronous control signals. It provides a debounced level, single-cycle press/release strobes, a single-cycle long-press strobe and a press counter. It sits directly upstream of the LED blink FSM and feeds that block's reset/mode inputs in place of the raw pad. Default timing assumes the 27 MHz board clock.

Parameters:
DEBOUNCE_CYCLES, 540000, cycles input must be stable to accept an edge (20 ms at 27 MHz); legal range >= 2
LONG_PRESS_CYCLES, 27000000, cycles held in PRESSED before long_press fires (1 s at 27 MHz); legal range >= 2
ACTIVE_LOW, 0, 0 = button reads 1 when pressed (pull-down wiring); 1 = button reads 0 when pressed (pull-up wiring)
CNT_W, 28, width of the internal counters; must hold max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)-1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_raw  in  1  raw button pad, asynchronous to clk
btn_level  out  1  debounced pressed level, 1 = pressed
press_pulse  out  1  one-cycle strobe on each accepted press
release_pulse  out  1  one-cycle strobe on each accepted release
long_press  out  1  one-cycle strobe, at most once per press
press_count  out  8  accepted presses modulo 256

Behaviour:
- Reset (async, rst=1): state=IDLE; all counters 0; long_fired=0; all outputs 0; press_count=0. Both synchroniser FFs load the inactive pad level (ACTIVE_LOW).
- Synchroniser: 2-FF chain on btn_raw. Normalised input: b = sync2 XOR ACTIVE_LOW. Only b is used downstream.
- All outputs are registered and update on the same edge as the state transition that causes them.
- IDLE: on b=1, go to PRESS_WAIT with db_cnt<=0.
- PRESS_WAIT:
  - b=0: return to IDLE; the bounce is rejected and no outputs change.
  - b=1 and db_cnt==DEBOUNCE_CYCLES-1: go to PRESSED. Set btn_level<=1, press_pulse<=1 for one cycle, press_count<=press_count+1 (wraps 255->0), hold_cnt<=0, long_fired<=0.
  - Otherwise: db_cnt++.
- PRESSED:
  - b=0: go to RELEASE_WAIT with db_cnt<=0.
  - Otherwise: hold_cnt++ while hold_cnt<LONG_PRESS_CYCLES-1, then it saturates.
  - When hold_cnt==LONG_PRESS_CYCLES-1 and long_fired=0: long_press<=1 for one cycle, long_fired<=1.
- RELEASE_WAIT:
  - b=1: return to PRESSED. hold_cnt and long_fired are preserved; no strobes.
  - b=0 and db_cnt==DEBOUNCE_CYCLES-1: go to IDLE. Set btn_level<=0, release_pulse<=1 for one cycle.
  - Otherwise: db_cnt++. hold_cnt is frozen.
- Latency: with btn_raw rising before edge 1 and held stable, press_pulse is high during the cycle after edge DEBOUNCE_CYCLES+3. This comprises 2 sync edges, 1 IDLE->PRESS_WAIT edge and DEBOUNCE_CYCLES counting edges. Release latency is identical.
- Strobes: press_pulse, release_pulse and long_press are never high for more than one consecutive cycle. press_pulse and release_pulse are never high in the same cycle.
- Invariant: btn_level=1 exactly in states PRESSED and RELEASE_WAIT.
- Reset mid-operation: any state returns immediately to IDLE. No release_pulse is generated. press_count clears.
- Illegal state encoding: recovers to IDLE on the next edge with outputs 0.

Test Plan:
- Clean press/release (D=4, L=16): hold btn_raw=1 for 10 cycles, then 0. Required: press_pulse 1 cycle, 7 cycles after the rise. btn_level=1 until release_pulse, which is 7 cycles after the fall. press_count=1. No long_press.
- Bounce rejection (D=4): toggle btn_raw 1,0,1,0 every 2 cycles, then hold 0. Required: no strobes, btn_level=0 throughout, press_count=0.
- Long press (D=4, L=16): hold btn_raw=1 for 40 cycles. Required: long_press exactly once, 16 cycles after press_pulse. A release bounce of 2 cycles low mid-hold produces no second long_press and no release_pulse.
- ACTIVE_LOW=1: btn_raw idles at 1 and is pulled to 0 for 10 cycles. Required: identical strobe timing to the first scenario, and no spurious press after reset deassertion.
- Reset mid-press: assert rst for 1 cycle while in PRESSED with press_count=5. Required: all outputs 0 and press_count=0 immediately. With btn_raw still held, a new press_pulse occurs 7 cycles after rst deasserts.
- Counter wrap: apply 256 clean presses. Required: press_count returns to 0 and press_pulse count is 256.
